// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - state encoding and default sizing for the main-memory line responder
package mem_pkg;

  localparam int DEFAULT_WORD_PER_BLOCK = 16;
  localparam int DEFAULT_WORD_SIZE      = 32;
  localparam int DEFAULT_ACCESS_LAT     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    RBURST,
    WBURST,
    WDONE
  } mem_state_e;

endpackage

// File: rtl/mem_word_ram.sv
// rtl/mem_word_ram.sv - word-organised main-memory storage, one write port and one synchronous read port
module mem_word_ram #(
  parameter int depth     = 1024,
  parameter int addr_w    = $clog2(depth),
  parameter int word_size = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [addr_w-1:0]    waddr,
  input  logic [word_size-1:0] wdata,
  input  logic                 re,
  input  logic [addr_w-1:0]    raddr,
  output logic [word_size-1:0] rdata
);

  logic [word_size-1:0] mem [depth];
  logic [word_size-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register only moves on re, so a stalled beat holds its word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_resp.sv
// rtl/main_mem_resp.sv - line-burst responder for main memory; MEM_CRIT_WORD_EN starts read bursts at req_offset
module main_mem_resp
  import mem_pkg::*;
#(
  parameter int block          = 1048576,
  parameter int word_per_block = DEFAULT_WORD_PER_BLOCK,
  parameter int word_size      = DEFAULT_WORD_SIZE,
  parameter int access_lat     = DEFAULT_ACCESS_LAT,
  parameter int line_bit       = $clog2(block),
  parameter int offset_bit     = $clog2(word_per_block)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [line_bit-1:0]   req_line,
  input  logic [offset_bit-1:0] req_offset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [word_size-1:0]  wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [word_size-1:0]  rd_data,
  output logic                  rd_last,
  output logic                  wr_done
);

  localparam int LAT_W = (access_lat > 1) ? $clog2(access_lat) : 1;
  localparam logic [offset_bit-1:0] LAST_BEAT = offset_bit'(word_per_block - 1);

  mem_state_e                state_d, state_q;
  logic                      write_d, write_q;
  logic [line_bit-1:0]       line_d, line_q;
  logic [offset_bit-1:0]     start_d, start_q;
  logic [offset_bit-1:0]     beat_d, beat_q;
  logic [LAT_W-1:0]          cnt_d, cnt_q;
  logic                      req_ready_d, req_ready_q;
  logic                      wr_ready_d, wr_ready_q;
  logic                      rd_valid_d, rd_valid_q;
  logic                      rd_last_d, rd_last_q;
  logic                      wr_done_d, wr_done_q;
  logic                      rd_hs, wr_hs, ram_re;
  logic [offset_bit-1:0]     crit_off;
  logic [line_bit+offset_bit-1:0] ram_raddr;

`ifdef MEM_CRIT_WORD_EN
  assign crit_off = req_offset;
`else
  logic unused_req_offset;
  assign unused_req_offset = ^req_offset;
  assign crit_off = '0;
`endif

  assign rd_hs = rd_valid_q && rd_ready;
  assign wr_hs = wr_ready_q && wr_valid;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    line_d  = line_q;
    start_d = start_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          line_d  = req_line;
          start_d = req_write ? '0 : crit_off;
          beat_d  = '0;
          cnt_d   = '0;
          if (access_lat == 0) state_d = req_write ? WBURST : RBURST;
          else                 state_d = LAT;
        end
      end
      LAT: begin
        if (cnt_q == LAT_W'(access_lat - 1)) state_d = write_q ? WBURST : RBURST;
        else                                 cnt_d   = cnt_q + LAT_W'(1);
      end
      RBURST: begin
        if (rd_hs) begin
          beat_d = beat_q + offset_bit'(1);
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      WBURST: begin
        if (wr_hs) begin
          beat_d = beat_q + offset_bit'(1);
          if (beat_q == LAST_BEAT) state_d = WDONE;
        end
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    wr_ready_d  = (state_d == WBURST);
    rd_valid_d  = (state_d == RBURST);
    rd_last_d   = (state_d == RBURST) && (beat_d == LAST_BEAT);
    wr_done_d   = (state_d == WDONE);

    // Fetch the word for the beat about to be presented: on burst entry and after each handshake.
    ram_re    = (state_d == RBURST) && ((state_q != RBURST) || rd_hs);
    ram_raddr = {line_d, offset_bit'(start_d + beat_d)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      line_q      <= '0;
      start_q     <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      line_q      <= line_d;
      start_q     <= start_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      wr_done_q   <= wr_done_d;
    end
  end

  mem_word_ram #(
    .depth     (block * word_per_block),
    .addr_w    (line_bit + offset_bit),
    .word_size (word_size)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_hs),
    .waddr ({line_q, beat_q}),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign wr_done   = wr_done_q;

endmodule

// File: doc/main_mem_resp.md
# main_mem_resp

Line-burst responder for the main-memory side of the cache hierarchy. It accepts one line request at a time from the cache controller over a valid/ready handshake and waits a fixed access latency. It then streams a full line of `word_per_block` words out (fill) or in (write-back), one word per handshake. It owns the word-organised main-memory storage and replaces direct array access by the cache.

## Interface
Parameters:
- `block`, 1048576, number of lines held in main memory
- `word_per_block`, 16, words per line (power of two)
- `word_size`, 32, bits per word
- `access_lat`, 4, idle cycles between request acceptance and first data beat (0 allowed)
- `line_bit`, `$clog2(block)`, line address width
- `offset_bit`, `$clog2(word_per_block)`, word offset width

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder idle, request accepted when both high
- `req_write`  in  1  0 = line read (fill), 1 = line write (write-back)
- `req_line`  in  `line_bit`  line address ({tag, index} of the cache)
- `req_offset`  in  `offset_bit`  critical word offset (used only with macro)
- `wr_valid`  in  1  write beat present
- `wr_ready`  out  1  responder accepting write beats
- `wr_data`  in  `word_size`  write beat data
- `rd_valid`  out  1  read beat present
- `rd_ready`  in  1  cache accepting read beat
- `rd_data`  out  `word_size`  read beat data
- `rd_last`  out  1  marks final beat of a read line
- `wr_done`  out  1  one-cycle pulse, write-back line committed

## Operation
- States: IDLE, LAT, RBURST, WBURST, WDONE.
- IDLE: `req_ready`=1. On accept, latch `req_write`, `req_line`, start offset; go to LAT (or directly to RBURST/WBURST if `access_lat`=0).
- LAT: count `access_lat` cycles; then RBURST if read, else WBURST.
- RBURST: present word at {line, ptr}; advance ptr on `rd_valid && rd_ready`; ptr is `offset_bit` wide and wraps modulo `word_per_block`. After `word_per_block` beats go to IDLE.
- WBURST: `wr_ready`=1; each `wr_valid && wr_ready` writes `wr_data` at {line, ptr}, ptr from 0 upward. After final beat go to WDONE.
- WDONE: `wr_done`=1 for exactly one cycle, then IDLE.
- `req_valid` outside IDLE is ignored. `wr_valid` outside WBURST and `rd_ready` without `rd_valid` are ignored.
- `rd_data` is stable while `rd_valid && !rd_ready`.
- Reset values: state IDLE, `req_ready`=1, `wr_ready`=0, `rd_valid`=0, `rd_last`=0, `wr_done`=0, `rd_data`=0. Memory contents are not reset.
- Reset mid-operation: the operation aborts immediately. Write beats already accepted remain in memory. No `wr_done` and no further `rd_valid` are produced.

## Timing
- Accept at cycle T. First `rd_valid` or `wr_ready` at T+`access_lat`+1.
- With no backpressure, a read line completes in `word_per_block` cycles. `rd_last` is high with the final beat, and `req_ready` returns the cycle after the last handshake.
- `wr_done` is high the cycle after the final write handshake, and `req_ready` returns the cycle after that.
- Storage read is synchronous: the next word is prefetched so back-to-back beats sustain one per cycle.

## Configuration
- `MEM_CRIT_WORD_EN` defined: a read burst starts at `req_offset` and wraps through the line. `rd_last` is on offset `req_offset`-1 (mod `word_per_block`).
- `MEM_CRIT_WORD_EN` undefined: `req_offset` is ignored and read bursts always start at offset 0.
- Write bursts start at 0 in both builds.

## Structure
- Package `mem_pkg`: state enum (IDLE, LAT, RBURST, WBURST, WDONE) and default parameter constants (`word_per_block`, `word_size`, `access_lat`).
- Sub-module `mem_word_ram`:
  - `block*word_per_block` × `word_size` storage.
  - One write port and one synchronous read port.
  - Address is {line, offset}.
- FSM, latency counter, beat pointer and output registers stay in `main_mem_resp`.

## Test plan
Benches use `block`=64 and `access_lat`=4.
- Write line 5 with 0x500+i, then read line 5 (offset 0) → 0x500..0x50F in order; `rd_last` only on 0x50F; first `rd_valid` at T+5; `wr_done` one cycle after the 16th write beat.
- Read line 5 with `rd_ready` toggling 1,0,0,1,… → each word held stable while stalled; no skip or duplicate; 16 beats total.
- `MEM_CRIT_WORD_EN` on, read line 5 offset 13 → 0x50D,0x50E,0x50F,0x500..0x50C, `rd_last` on 0x50C. Macro off, same request → starts at 0x500.
- Write line 9 (old 0x900+i) with new 0xA00+i; assert `rst` after 7 beats → IDLE with `req_ready`=1 and no `wr_done`. Readback gives 0xA00..0xA06, then 0x907..0x90F.
- `req_valid` held high during a busy burst → second request accepted only in IDLE after completion. With `access_lat`=0, first `rd_valid` at T+1.
- Write with `wr_valid` gaps of 2 cycles between beats → memory correct; `wr_done` exactly one pulse.
